// File: rtl/riscv_lsu.sv
// Multicycle RV32 load/store unit: alignment checks, byte-enable/store formatting, req/ready memory handshake.
// Optional watchdog on the memory handshake is enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DMEM_ADDR      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 we_i,
    input  logic [2:0]           funct3_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      wdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [XLEN-1:0]      rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [DMEM_ADDR-1:0] mem_addr_o,
    output logic [XLEN-1:0]      mem_wdata_o,
    input  logic                 mem_ready_i,
    input  logic [XLEN-1:0]      mem_rdata_i
);

    localparam int unsigned AW = DMEM_ADDR + 2;

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("riscv_lsu: unsupported configuration");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t          state, state_n;
    logic            lat_we;
    logic [2:0]      lat_funct3;
    logic [AW-1:0]   lat_addr;
    logic [XLEN-1:0] lat_wdata;

    logic            accept;
    logic            illegal;
    logic            timeout_hit;
    logic            src_we;
    logic [2:0]      src_funct3;
    logic [AW-1:0]   src_addr;
    logic [XLEN-1:0] src_wdata;
    logic [3:0]      fmt_be;
    logic [XLEN-1:0] fmt_wdata;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_fmt;

    logic                 busy_n, done_n, err_n, req_n, we_n;
    logic [3:0]           be_n;
    logic [DMEM_ADDR-1:0] addr_n;
    logic [XLEN-1:0]      wdata_n;

    logic unused_addr;
    assign unused_addr = ^addr_i[XLEN-1:AW];

    // Live inputs are used on the accept cycle, latched copies afterwards.
    always_comb begin
        src_we     = (state == IDLE) ? we_i            : lat_we;
        src_funct3 = (state == IDLE) ? funct3_i        : lat_funct3;
        src_addr   = (state == IDLE) ? addr_i[AW-1:0]  : lat_addr;
        src_wdata  = (state == IDLE) ? wdata_i         : lat_wdata;
    end

    // Legality of funct3 for the access type plus natural alignment.
    always_comb begin
        illegal = 1'b0;
        case (src_funct3)
            3'b000:         illegal = 1'b0;
            3'b001:         illegal = src_addr[0];
            3'b010:         illegal = (src_addr[1:0] != 2'b00);
            3'b100:         illegal = src_we;
            3'b101:         illegal = src_we | src_addr[0];
            default:        illegal = 1'b1;
        endcase
    end

    // Store byte enables and lane-replicated data; loads read the whole word.
    always_comb begin
        fmt_be    = 4'b1111;
        fmt_wdata = src_wdata;
        if (src_we) begin
            case (src_funct3[1:0])
                2'b00: begin
                    fmt_be    = 4'(4'b0001 << src_addr[1:0]);
                    fmt_wdata = {4{src_wdata[7:0]}};
                end
                2'b01: begin
                    fmt_be    = src_addr[1] ? 4'b1100 : 4'b0011;
                    fmt_wdata = {2{src_wdata[15:0]}};
                end
                default: begin
                    fmt_be    = 4'b1111;
                    fmt_wdata = src_wdata;
                end
            endcase
        end
    end

    // Load result extraction and extension.
    always_comb begin
        shifted  = mem_rdata_i >> {lat_addr[1:0], 3'b000};
        load_fmt = shifted;
        case (lat_funct3)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'h0, shifted[7:0]};
            3'b101:  load_fmt = {16'h0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != REQ) tmo_cnt <= '0;
        else                     tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    assign timeout_hit = (state == REQ) && (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: if (start_i) begin
                accept  = 1'b1;
                state_n = illegal ? ERR : REQ;
            end
            REQ: begin
                if (mem_ready_i)      state_n = RESP;
                else if (timeout_hit) state_n = ERR;
            end
            RESP:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == RESP) || (state_n == ERR);
        err_n   = (state_n == ERR);
        req_n   = (state_n == REQ);
        we_n    = req_n && src_we;
        be_n    = req_n ? fmt_be : 4'b0000;
        addr_n  = req_n ? src_addr[AW-1:2] : '0;
        wdata_n = (req_n && src_we) ? fmt_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_funct3  <= 3'b000;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state       <= state_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
            err_o       <= err_n;
            mem_req_o   <= req_n;
            mem_we_o    <= we_n;
            mem_be_o    <= be_n;
            mem_addr_o  <= addr_n;
            mem_wdata_o <= wdata_n;
            if (accept) begin
                lat_we     <= we_i;
                lat_funct3 <= funct3_i;
                lat_addr   <= addr_i[AW-1:0];
                lat_wdata  <= wdata_i;
            end
            if (state == REQ && mem_ready_i && !lat_we) rdata_o <= load_fmt;
        end
    end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Multicycle load/store unit between the core controller's memory states (S_MEM_RD / S_MEM_WR) and the word-organised data memory. Accepts one access per start pulse, latches address, funct3, and store data, and performs alignment checks. Generates byte enables and replicated store data, handshakes with memory via req/ready, and returns sign- or zero-extended load data with a one-cycle done pulse.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DMEM_ADDR, 12, word-address width presented to data memory (4096 words).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle request from the controller; ignored while busy_o=1.
- we_i  in  1  access type: 1=store, 0=load.
- funct3_i  in  3  load encoding (B=000, H=001, W=010, BU=100, HU=101) or store encoding (B=000, H=001, W=010).
- addr_i  in  32  byte address.
- wdata_i  in  32  store source register value.
- busy_o  out  1  high from the cycle after start until the cycle of done_o, inclusive.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: misaligned access, illegal funct3, or timeout.
- rdata_o  out  32  formatted load result; holds its value until the next completed load.
- mem_req_o  out  1  memory request; held until mem_ready_i is sampled high.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables; all 1 for loads.
- mem_addr_o  out  DMEM_ADDR  word address, taken from addr[DMEM_ADDR+1:2]; upper bits are discarded (wrap).
- mem_wdata_o  out  32  replicated store data.
- mem_ready_i  in  1  memory accepts or completes the access this cycle; mem_rdata_i is valid on the same cycle.
- mem_rdata_i  in  32  word read data.

## Operation
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE, start_i=1: latch we, funct3, addr, wdata.
  - If the access is illegal, go to ERR.
  - Otherwise go to REQ.
- Illegal access:
  - funct3 not in the valid set for the access type.
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
- REQ: mem_req_o=1 with stable address, be, and wdata.
  - mem_ready_i=1: capture mem_rdata_i (loads only) and go to RESP.
  - mem_ready_i=0: stay in REQ.
- RESP: done_o=1, err_o=0, update rdata_o (loads only); go to IDLE.
- ERR: done_o=1, err_o=1, rdata_o unchanged, no memory access; go to IDLE.
- Store formatting:
  - SB: be = 0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; data = {2{wdata[15:0]}}.
  - SW: be = 1111; data = wdata.
- Load formatting: shifted = mem_rdata >> (8*addr[1:0]).
  - LB / LH sign-extend bit 7 / bit 15.
  - LBU / LHU zero-extend.
  - LW passes the full word.
- When idle, all mem_* outputs are 0. mem_we_o is asserted only in REQ with we=1.

## Timing
- Reset values: FSM=IDLE; busy_o, done_o, err_o, mem_req_o, mem_we_o = 0; mem_be_o = 0000; mem_addr_o, mem_wdata_o, rdata_o = 0.
- Start sampled at cycle 0, legal access: mem_req_o high from cycle 1. Ready at cycle 1+k gives done_o at cycle 2+k. Minimum latency is 2 cycles.
- Illegal access: done_o and err_o at cycle 1; mem_req_o never rises.
- start_i during busy_o is dropped with no side effects. start_i in the done_o cycle is also ignored, because busy_o is still high.
- A new start is accepted the cycle after done_o, allowing back-to-back accesses every 3 cycles at minimum.
- rst in any state: next cycle is IDLE with reset outputs; an in-flight request is abandoned and mem_req_o drops.

## Configuration
- LSU_TIMEOUT_EN defined: an 8+-bit counter clears on entry to REQ and increments each REQ cycle.
  - If the counter reaches TIMEOUT_CYCLES without mem_ready_i, go to ERR (done_o=1, err_o=1) and drop mem_req_o.
  - mem_ready_i on the same cycle as the limit wins: the access completes normally.
- LSU_TIMEOUT_EN undefined: no counter exists and REQ waits indefinitely.

## Test plan
- SW, addr=0x0000_0104, wdata=0xDEADBEEF, ready immediate: mem_addr_o=0x041, be=1111, mem_wdata_o=0xDEADBEEF; done_o 2 cycles after start, err_o=0.
- SB, addr=0x0000_0007, wdata=0x0000_00A5: be=1000, mem_wdata_o=0xA5A5A5A5.
- LB, addr=0x3, mem_rdata=0x8012_3456 with ready delayed 3 cycles: rdata_o=0xFFFF_FF80, done_o at cycle 5. Repeat as LBU: rdata_o=0x0000_0080. LHU at addr=0x2: rdata_o=0x0000_8012.
- LW at addr=0x2: done_o and err_o at cycle 1, mem_req_o stays 0, rdata_o unchanged. Repeat with load funct3=011: err_o=1.
- start_i pulsed while in REQ: ignored, single done_o. rst asserted mid-REQ: mem_req_o=0 and busy_o=0 next cycle, no done_o.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready held low: err_o with done_o, mem_req_o deasserted, FSM back in IDLE.
